// File: rtl/sl_pkg.sv
// Shared definitions for the SL serial-line blocks (transmitter, bridge, receiver).
// Holds the FSM state type, configuration field positions and line timing constants.
package sl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GAP
    } sl_tx_state_t;

    localparam int CFG_PAR_EN    = 0;
    localparam int CFG_PAR_ODD   = 1;
    localparam int CFG_HALF_LSB  = 2;
    localparam int CFG_HALF_MSB  = 7;

    localparam int GAP_HALF_BITS = 4;
    localparam int HALF_W        = CFG_HALF_MSB - CFG_HALF_LSB + 1;
    localparam int BIT_CNT_W     = 6;

endpackage

// File: rtl/sl_half_bit_timer.sv
// Loadable down-counter timing one half-bit phase; phase_end is high while the count is zero.
// A phase loaded with H therefore lasts H+1 clocks.
module sl_half_bit_timer #(
    parameter int HALF_W = sl_pkg::HALF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HALF_W-1:0] load_val,
    output logic              phase_end
);

    logic [HALF_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/sl_tx.sv
// SL two-wire transmitter: serializes a 32-bit word MSB-first with optional parity,
// followed by an idle gap, and returns a ready/done handshake to the bridge.
module sl_tx #(
    parameter int WORD_WIDTH       = 32,
    parameter int CONFIG_REG_WIDTH = 8,
    parameter int GAP_HALF_BITS    = sl_pkg::GAP_HALF_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WORD_WIDTH-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [CONFIG_REG_WIDTH-1:0] config_reg,
    output logic                        sl0,
    output logic                        sl1,
    output logic                        busy,
    output logic                        tx_done
);
    import sl_pkg::*;

    localparam logic [BIT_CNT_W-1:0] GAP_LAST = BIT_CNT_W'(GAP_HALF_BITS - 1);

    sl_tx_state_t          state;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  last_bit;
    logic [HALF_W-1:0]     half_q;
    logic [HALF_W-1:0]     cfg_half;
    logic [HALF_W-1:0]     timer_val;
    logic                  par_en_q;
    logic [WORD_WIDTH:0]   shreg;
    logic                  accept;
    logic                  timer_load;
    logic                  phase_end;

    assign accept     = tx_valid && tx_ready;
    assign cfg_half   = config_reg[CFG_HALF_MSB:CFG_HALF_LSB];
    // The accepting edge already starts the first LOW phase, so the timer takes H straight from the input.
    assign timer_load = accept || ((state != IDLE) && phase_end);
    assign timer_val  = accept ? cfg_half : half_q;
    assign last_bit   = par_en_q ? BIT_CNT_W'(WORD_WIDTH) : BIT_CNT_W'(WORD_WIDTH - 1);

    sl_half_bit_timer #(
        .HALF_W   (HALF_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .phase_end(phase_end)
    );

    // Word and latched configuration; the parity bit rides at the LSB end of the shifter.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg    <= {tx_data, (^tx_data) ^ config_reg[CFG_PAR_ODD]};
            half_q   <= cfg_half;
            par_en_q <= config_reg[CFG_PAR_EN];
        end else if ((state == HIGH) && phase_end) begin
            shreg <= shreg << 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sl0      <= 1'b1;
            sl1      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= LOW;
                        bit_cnt  <= '0;
                        sl0      <= tx_data[WORD_WIDTH-1];
                        sl1      <= ~tx_data[WORD_WIDTH-1];
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state <= HIGH;
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        if (bit_cnt == last_bit) begin
                            state   <= GAP;
                            bit_cnt <= '0;
                        end else begin
                            // shreg has not shifted yet, so the next bit sits one below the top.
                            state   <= LOW;
                            bit_cnt <= bit_cnt + 1'b1;
                            sl0     <= shreg[WORD_WIDTH-1];
                            sl1     <= ~shreg[WORD_WIDTH-1];
                        end
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        if (bit_cnt == GAP_LAST) begin
                            state    <= IDLE;
                            bit_cnt  <= '0;
                            tx_done  <= 1'b1;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sl_tx.sv
// Scoreboard bench for sl_tx: expected bits and done times are queued per word and
// checked against the decoded sl0/sl1 lines, sampled on the falling clock edge.
module tb_sl_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  config_reg;
    logic        sl0;
    logic        sl1;
    logic        busy;
    logic        tx_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_bits[$];
    int   exp_done[$];

    always #5 clk = ~clk;

    sl_tx dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .config_reg(config_reg),
        .sl0       (sl0),
        .sl1       (sl1),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // Queue the first nkeep bits of a word (data MSB-first, then the given parity bit if enabled).
    task automatic push_word(input logic [31:0] d, input logic par_en, input logic par_bit, input int nkeep);
        int n;
        n = par_en ? 33 : 32;
        for (int i = 0; i < n && i < nkeep; i++) begin
            if (i < 32) exp_bits.push_back(d[31-i]);
            else        exp_bits.push_back(par_bit);
        end
    endtask

    task automatic start(input logic [31:0] d, input logic [7:0] cfg);
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_accept: got %b expected 1", tx_ready);
        end
        tx_data    = d;
        config_reg = cfg;
        tx_valid   = 1'b1;
    endtask

    // Sample index k = 0 is the cycle right after the accepting edge.
    task automatic monitor(input int ncyc, input int hlen);
        logic prev_hi;
        logic b;
        logic e;
        int   low_len;
        int   d;
        prev_hi = 1'b1;
        low_len = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            n_tests++;
            if (sl0 === 1'b0 && sl1 === 1'b0) begin
                n_fail++;
                $display("FAIL both_low k=%0d: got sl0=%b sl1=%b expected not both 0", k, sl0, sl1);
            end
            n_tests++;
            if (busy !== ~tx_ready) begin
                n_fail++;
                $display("FAIL busy_vs_ready k=%0d: got busy=%b expected %b", k, busy, ~tx_ready);
            end
            if (sl0 === 1'b0 || sl1 === 1'b0) begin
                if (prev_hi) begin
                    b = (sl1 === 1'b0);
                    n_tests++;
                    if (exp_bits.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_bit k=%0d: got bit %b expected none", k, b);
                    end else begin
                        e = exp_bits.pop_front();
                        if (b !== e) begin
                            n_fail++;
                            $display("FAIL bit_value k=%0d: got %b expected %b", k, b, e);
                        end
                    end
                    low_len = 0;
                end
                low_len++;
                prev_hi = 1'b0;
            end else begin
                if (!prev_hi) begin
                    n_tests++;
                    if (low_len != hlen + 1) begin
                        n_fail++;
                        $display("FAIL low_phase_len k=%0d: got %0d expected %0d", k, low_len, hlen + 1);
                    end
                end
                prev_hi = 1'b1;
            end
            if (tx_done === 1'b1) begin
                n_tests++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done k=%0d: got pulse expected none", k);
                end else begin
                    d = exp_done.pop_front();
                    if (k != d) begin
                        n_fail++;
                        $display("FAIL done_time: got %0d expected %0d", k, d);
                    end
                end
            end
        end
        n_tests++;
        if (exp_bits.size() != 0 || exp_done.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d bits %0d dones pending expected 0 0", exp_bits.size(), exp_done.size());
        end
        exp_bits.delete();
        exp_done.delete();
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_tests++;
        if (sl0 !== 1'b1 || sl1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_lines: got sl0=%b sl1=%b expected 1 1", sl0, sl1);
        end
        n_tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b expected 1 0 0", tx_ready, busy, tx_done);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1 || sl0 !== 1'b1 || sl1 !== 1'b1 || tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ready=%b sl0=%b sl1=%b done=%b expected 1 1 1 0", tx_ready, sl0, sl1, tx_done);
        end
    endtask

    task automatic test_no_parity;
        push_word(32'hA5A5A5A5, 1'b0, 1'b0, 99);
        exp_done.push_back(68);
        start(32'hA5A5A5A5, 8'h00);
        fork
            monitor(90, 0);
            begin
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
    endtask

    task automatic test_even_parity;
        push_word(32'h00000001, 1'b1, 1'b1, 99);
        exp_done.push_back(70);
        start(32'h00000001, 8'h01);
        fork
            monitor(90, 0);
            begin
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
    endtask

    task automatic test_odd_parity;
        push_word(32'h00000001, 1'b1, 1'b0, 99);
        exp_done.push_back(280);
        start(32'h00000001, 8'h0F);
        fork
            monitor(300, 3);
            begin
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
    endtask

    // 0x12345678 has 13 ones, so even parity adds a 1; H=1 from the latched config.
    task automatic test_cfg_change;
        push_word(32'h12345678, 1'b1, 1'b1, 99);
        exp_done.push_back(140);
        start(32'h12345678, 8'h05);
        fork
            monitor(170, 1);
            begin
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (10) @(negedge clk);
                config_reg = 8'hFC;
                tx_data    = 32'h0;
            end
        join
        config_reg = 8'h00;
    endtask

    task automatic test_back_to_back;
        push_word(32'hF0F0F0F0, 1'b0, 1'b0, 99);
        push_word(32'h0F0F0F0F, 1'b0, 1'b0, 99);
        exp_done.push_back(68);
        exp_done.push_back(137);
        start(32'hF0F0F0F0, 8'h00);
        fork
            monitor(170, 0);
            begin
                @(negedge clk);
                tx_data = 32'h0F0F0F0F;
                repeat (69) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
    endtask

    // Reset lands during the LOW phase of the 11th bit; only those 11 bits may appear.
    task automatic test_reset_mid;
        push_word(32'hA5A5A5A5, 1'b0, 1'b0, 11);
        start(32'hA5A5A5A5, 8'h00);
        fork
            monitor(60, 0);
            begin
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (20) @(negedge clk);
                #1 reset = 1'b1;
                #1;
                n_tests++;
                if (sl0 !== 1'b1 || sl1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL async_reset_lines: got sl0=%b sl1=%b expected 1 1", sl0, sl1);
                end
                repeat (3) @(negedge clk);
                reset = 1'b0;
                #1;
                n_tests++;
                if (tx_ready !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_after_reset: got ready=%b busy=%b expected 1 0", tx_ready, busy);
                end
            end
        join
    endtask

    initial begin
        reset      = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 32'h0;
        config_reg = 8'h00;
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_cfg_change();
        test_back_to_back();
        test_reset_mid();
        test_no_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
